dac_gearbox_8to5: RTL
=====================

# dac_gearbox_8to5

Upstream feeder for `dac_if_5to2`. It runs in the `clkout` domain and accepts 8-sample beats from the sample source through a valid/ready handshake. Every `clkout` cycle it presents exactly five time-ordered 14-bit samples on `data_out`, which drives `data_in` of `dac_if_5to2`. It also handles startup priming and underflow (midscale fill plus a counter), and provides a built-in ramp test pattern for link bring-up.

## Interface
Parameters:
- `W`, 14, sample width in bits, offset binary.
- `MIDSCALE`, 14'h2000, fill value during idle or underflow.

Ports:
- `clkout`  in  1  DAC word clock, the `clkout` of `dac_if_5to2`. This is the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  stream enable. Low flushes the buffer and outputs midscale.
- `pattern_en`  in  1  ramp test-pattern mode. Has priority over streaming.
- `s_data`  in  [7:0][W-1:0]  input beat. Lane 0 is the earliest sample.
- `s_valid`  in  1  beat valid.
- `s_ready`  out  1  beat accept.
- `data_out`  out  [4:0][W-1:0]  DAC word. Lane 0 is the earliest sample. Connects to `data_in` of `dac_if_5to2`.
- `underflow`  out  1  one-cycle pulse per underflowed output word.
- `underflow_count`  out  16  saturating underflow counter.
- `level`  out  4  buffered sample count, 0..12.

## Operation
- The residue buffer holds 12 samples of W bits, plus `level` (0..12).
- Push: a beat is accepted when `s_valid && s_ready`. Its eight samples are appended after the current `level` samples in lane order.
- `s_ready = enable && !pattern_en && (level <= 9)`.
  - It depends only on registered state. There is no combinational path from `s_valid`.
  - A push can therefore never overflow: `level` never exceeds 12.
- Pop (streaming: `enable=1`, `pattern_en=0`):
  - If `level >= 5`, buffer entries 0..4 go to `data_out` lanes 0..4, and the remaining samples shift down by 5.
  - If `level < 5`, this is an underflow:
    - `data_out` = `MIDSCALE` on all lanes, and no samples are consumed.
    - `underflow` pulses and `underflow_count` increments, saturating at 16'hFFFF.
    - Exception: no underflow is flagged before the first successful pop after `enable` rises (priming). A `primed` flag is set on the first pop and cleared when `enable=0`, on `pattern_en`, or on `reset`.
- Same-cycle push and pop: the pop applies first, then the push appends at position `level-5`. The next `level` is `level - 5*pop + 8*push`.
- Disabled (`enable=0`): `level` is forced to 0, `data_out` is `MIDSCALE`, and no underflow is flagged.
- Pattern mode (`pattern_en=1`, with any value of `enable`):
  - `data_out[i] = base + i` modulo 2^W, and `base` advances by 5 each cycle (wrapping at 2^W).
  - `base` resets to 0 on the cycle `pattern_en` rises.
  - The buffer is flushed (`level=0`), `s_ready=0`, and no underflow is flagged.
  - On exit from pattern mode, streaming re-primes.
- Arithmetic: all sample values pass through unmodified. Only `base` and the counter do arithmetic, and both wrap/saturate as stated.

## Timing
- Reset values (synchronous, on the `clkout` edge with `reset=1`):
  - `level=0`, `s_ready=0`, `data_out` = all lanes `MIDSCALE`.
  - `underflow=0`, `underflow_count=0`, `base=0`, `primed=0`.
- Reset asserted mid-stream discards buffered samples. The next cycle already shows the reset values.
- `data_out` and `underflow` are registered: they reflect the pop decision made in the previous cycle.
- Latency: a beat accepted at edge N can appear on `data_out` at edge N+1 at the earliest, when it arrives with `level` ≥ 0 and fills to ≥ 5.
- Steady-state throughput:
  - The consumer takes 5 samples per cycle.
  - With a continuously valid source, `s_ready` settles to a repeating 8-cycle pattern with 5 accepts.
  - `data_out` is gap-free.
- `level` updates at the same edge as `data_out`.
- `underflow_count` is registered and increments at the same edge that `underflow` goes high.

## Test plan
- Reset check: hold `reset` for 3 cycles with `s_valid=1` → `s_ready=0`, all `data_out` lanes = 14'h2000, `level=0`, `underflow_count=0`.
- Continuous stream: `enable=1`, source ramp sample k = k, `s_valid` always 1 → after priming, `data_out[i]` = 5m+i on consecutive cycles with no gaps. Check 200 words, and check that `s_ready` is high 5 of every 8 cycles.
- Underflow: deliver exactly 2 beats (samples 0..15), then `s_valid=0` → three words 0..4, 5..9, 10..14. Next cycle: midscale, `underflow`=1, `count=1`, `level=1`. Resume the source → the next word is 15..19.
- Backpressure boundary: force `level=10` by stalling → `s_ready=0`. After one pop, `level=5` → `s_ready=1`. A same-cycle push+pop at `level=9` → `level=12`, with no data loss.
- Pattern mode: assert `pattern_en` → `data_out` = {4,3,2,1,0}, then {9,8,7,6,5}, and so on. After 3277 cycles `base` wraps past 16383 correctly. `s_ready=0` and `underflow` is never set.
- Disable mid-stream: drop `enable` with `level=7` → the next `level=0` and the output is midscale. Re-enable → the first words come from fresh beats, with no underflow during priming.

Source files
------------

// File: rtl/dac_gearbox_8to5.sv
// 8-sample-beat to 5-sample-word gearbox feeding dac_if_5to2, with priming,
// underflow fill/counting and a ramp test pattern. Single clock: clkout.
module dac_gearbox_8to5 #(
  parameter int             W        = 14,
  parameter logic [W-1:0]   MIDSCALE = 14'h2000
) (
  input  logic                clkout,
  input  logic                reset,
  input  logic                enable,
  input  logic                pattern_en,
  input  logic [7:0][W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [4:0][W-1:0]   data_out,
  output logic                underflow,
  output logic [15:0]         underflow_count,
  output logic [3:0]          level
);

  localparam int DEPTH = 12;

  logic [W-1:0] sample_buf [DEPTH];
  logic [W-1:0] buf_next   [DEPTH];
  logic         primed;
  logic         pattern_q;
  logic [W-1:0] base;
  logic [W-1:0] base_cur;
  logic         pop;
  logic         push;
  logic [3:0]   wr_ptr;

  // Reset is folded in so no beat is taken while the block is being reset.
  assign s_ready  = !reset && enable && !pattern_en && (level <= 4'd9);
  assign push     = s_valid && s_ready;
  assign pop      = (level >= 4'd5);
  assign wr_ptr   = pop ? level - 4'd5 : level;
  assign base_cur = pattern_q ? base : '0;

  // Pop shifts first, then the beat lands at wr_ptr; offsets outside 0..7
  // wrap to large 4-bit values and are ignored.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) buf_next[i] = sample_buf[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 5; i++) buf_next[i] = sample_buf[i+5];
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((4'(i) - wr_ptr) < 4'd8) buf_next[i] = s_data[3'(4'(i) - wr_ptr)];
      end
    end
  end

  // NOTE: the sample storage has no reset; level alone defines which entries
  // are valid, so stale contents are never observed.
  always_ff @(posedge clkout) begin
    for (int i = 0; i < DEPTH; i++) sample_buf[i] <= buf_next[i];
  end

  always_ff @(posedge clkout) begin
    if (reset) begin
      level           <= '0;
      data_out        <= {5{MIDSCALE}};
      underflow       <= 1'b0;
      underflow_count <= '0;
      base            <= '0;
      primed          <= 1'b0;
      pattern_q       <= 1'b0;
    end else begin
      underflow <= 1'b0;
      pattern_q <= pattern_en;
      if (pattern_en) begin
        level  <= '0;
        primed <= 1'b0;
        for (int i = 0; i < 5; i++) data_out[i] <= base_cur + W'(i);
        base   <= base_cur + W'(5);
      end else if (!enable) begin
        level    <= '0;
        primed   <= 1'b0;
        data_out <= {5{MIDSCALE}};
      end else begin
        level <= wr_ptr + (push ? 4'd8 : 4'd0);
        if (pop) begin
          for (int i = 0; i < 5; i++) data_out[i] <= sample_buf[i];
          primed <= 1'b1;
        end else begin
          data_out <= {5{MIDSCALE}};
          // Before the first pop after enable the link is still priming.
          if (primed) begin
            underflow <= 1'b1;
            if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
          end
        end
      end
    end
  end

endmodule
